// File: rtl/mem_resp.sv
// mem_resp: single-outstanding request/response sequencer in front of a
// synchronous BRAM. Accepts fetch/load/store requests in IDLE, issues them to
// the BRAM, and returns a one-cycle response pulse. A fetch response can be
// discarded by a flush (taken branch/jump).
//
// Optional feature (macro MEM_RESP_STORE_FWD_EN): a one-entry store-forward
// register lets a load that hits the most recent in-range store return in one
// cycle without reading the BRAM. With the macro undefined every load takes
// the BRAM path.
module mem_resp #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [1:0]        req_type,
    input  logic [15:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    input  logic              flush,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    output logic              bram_we,
    input  logic [DATA_W-1:0] bram_dout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_RESP  = 2'b11
    } state_t;

    localparam logic [1:0] T_FETCH = 2'b00;
    localparam logic [1:0] T_STORE = 2'b10;

    // Registered transaction context
    state_t            r_state;
    logic [1:0]        r_type;
    logic              r_oor;
    logic              r_drop;
    logic [DATA_W-1:0] r_rdata;

    // Combinational next values
    state_t            w_state_nxt;
    logic [1:0]        w_type_nxt;
    logic              w_oor_nxt;
    logic              w_drop_nxt;
    logic [DATA_W-1:0] w_rdata_nxt;
    logic [ADDR_W-1:0] w_bram_addr_nxt;
    logic [DATA_W-1:0] w_bram_din_nxt;
    logic              w_bram_we_nxt;
    logic              w_rsp_valid_nxt;
    logic [DATA_W-1:0] w_rsp_data_nxt;
    logic              w_rsp_err_nxt;
    logic              w_req_ready_nxt;

    // Request decode
    logic              w_accept;
    logic              w_req_oor;
    logic              w_req_store;
    logic              w_req_fetch;
    logic              w_flush_fetch;
    logic              w_fwd_hit;
    logic [DATA_W-1:0] w_fwd_data;

    // Decode of the incoming request and of flush against the held request
    assign w_accept      = req_valid & req_ready & (r_state == S_IDLE);
    assign w_req_oor     = (req_addr >> ADDR_W) != 16'd0;
    assign w_req_store   = (req_type == T_STORE);
    assign w_req_fetch   = (req_type == T_FETCH);
    assign w_flush_fetch = flush & (r_type == T_FETCH);

`ifdef MEM_RESP_STORE_FWD_EN
    logic              w_req_load;
    logic              r_fwd_vld;
    logic [ADDR_W-1:0] r_fwd_addr;
    logic [DATA_W-1:0] r_fwd_data;

    // Reserved type 11 behaves as a load and may forward as well
    assign w_req_load = req_type[0];
    assign w_fwd_hit  = r_fwd_vld & w_req_load & ~w_req_oor &
                        (r_fwd_addr == req_addr[ADDR_W-1:0]);
    assign w_fwd_data = r_fwd_data;

    // Forward entry tracks the most recent in-range store
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fwd_vld  <= 1'b0;
            r_fwd_addr <= '0;
            r_fwd_data <= '0;
        end else if (w_accept & w_req_store & ~w_req_oor) begin
            r_fwd_vld  <= 1'b1;
            r_fwd_addr <= req_addr[ADDR_W-1:0];
            r_fwd_data <= req_wdata;
        end
    end
`else
    assign w_fwd_hit  = 1'b0;
    assign w_fwd_data = '0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_fwd_hit ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: w_state_nxt = (r_type == T_STORE) ? S_RESP : S_WAIT;
            S_WAIT:  w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output and datapath next values; BRAM controls are set up on accept so
    // that they are valid while the FSM sits in ISSUE
    always_comb begin
        w_type_nxt      = r_type;
        w_oor_nxt       = r_oor;
        w_drop_nxt      = r_drop;
        w_rdata_nxt     = r_rdata;
        w_bram_addr_nxt = bram_addr;
        w_bram_din_nxt  = bram_din;
        w_bram_we_nxt   = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_data_nxt  = rsp_data;
        w_rsp_err_nxt   = rsp_err;
        w_req_ready_nxt = (w_state_nxt == S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_type_nxt  = req_type;
                    w_oor_nxt   = w_req_oor;
                    w_drop_nxt  = flush & w_req_fetch;
                    w_rdata_nxt = w_fwd_hit ? w_fwd_data : '0;
                    if (!w_fwd_hit) begin
                        w_bram_addr_nxt = req_addr[ADDR_W-1:0];
                        w_bram_din_nxt  = req_wdata;
                        w_bram_we_nxt   = w_req_store & ~w_req_oor;
                    end
                end
            end
            S_ISSUE: begin
                if (w_flush_fetch) begin
                    w_drop_nxt = 1'b1;
                end
            end
            S_WAIT: begin
                if (w_flush_fetch) begin
                    w_drop_nxt = 1'b1;
                end
                w_rdata_nxt = r_oor ? '0 : bram_dout;
            end
            S_RESP: begin
                // A flush arriving in RESP itself still kills the fetch pulse
                if (!(r_drop | w_flush_fetch)) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_data_nxt  = r_rdata;
                    w_rsp_err_nxt   = r_oor;
                end
                w_drop_nxt = 1'b0;
            end
            default: begin
                w_drop_nxt = 1'b0;
            end
        endcase
    end

    // Registered outputs and transaction context
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_type    <= 2'b00;
            r_oor     <= 1'b0;
            r_drop    <= 1'b0;
            r_rdata   <= '0;
            bram_addr <= '0;
            bram_din  <= '0;
            bram_we   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            r_type    <= w_type_nxt;
            r_oor     <= w_oor_nxt;
            r_drop    <= w_drop_nxt;
            r_rdata   <= w_rdata_nxt;
            bram_addr <= w_bram_addr_nxt;
            bram_din  <= w_bram_din_nxt;
            bram_we   <= w_bram_we_nxt;
            rsp_valid <= w_rsp_valid_nxt;
            rsp_data  <= w_rsp_data_nxt;
            rsp_err   <= w_rsp_err_nxt;
            req_ready <= w_req_ready_nxt;
        end
    end

endmodule
